// File: rtl/bcs_pkg.sv
// Shared constants for the bit-serial comparator: FSM state encodings and default operand width.
package bcs_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

endpackage

// File: rtl/bcs_bit_cell.sv
// Single equal/greater cascade cell: folds one MSB-first bit pair into the running e/g state.
module bcs_bit_cell (
    input  logic a,
    input  logic b,
    input  logic e_in,
    input  logic g_in,
    output logic e_out,
    output logic g_out
);

    assign e_out = e_in & ~(a ^ b);
    assign g_out = g_in | (e_in & b & ~a);

endmodule

// File: rtl/bcs_serial_comparator.sv
// Bit-serial magnitude comparator: captures two operands on start, walks them MSB first through
// one cascade cell and reports A==B / B>A / A>B with a one-cycle done pulse.
module bcs_serial_comparator
    import bcs_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter bit          EARLY_EXIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             a_eq_b,
    output logic             b_gt_a,
    output logic             a_gt_b
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             e;
    logic             g;
    logic [CNT_W-1:0] cnt;
    logic             res_eq;
    logic             res_bgt;
    logic             res_agt;
    logic             e_nxt;
    logic             g_nxt;
    logic             last;

    bcs_bit_cell u_cell (
        .a     (a_sh[WIDTH-1]),
        .b     (b_sh[WIDTH-1]),
        .e_in  (e),
        .g_in  (g),
        .e_out (e_nxt),
        .g_out (g_nxt)
    );

    // Once e drops the outcome is fixed, so early exit can stop there.
    assign last = (cnt == '0) || (EARLY_EXIT && !e_nxt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            e       <= 1'b1;
            g       <= 1'b0;
            cnt     <= '0;
            res_eq  <= 1'b0;
            res_bgt <= 1'b0;
            res_agt <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh    <= a_in;
                        b_sh    <= b_in;
                        e       <= 1'b1;
                        g       <= 1'b0;
                        cnt     <= CNT_W'(WIDTH - 1);
                        res_eq  <= 1'b0;
                        res_bgt <= 1'b0;
                        res_agt <= 1'b0;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    e    <= e_nxt;
                    g    <= g_nxt;
                    a_sh <= {a_sh[WIDTH-2:0], 1'b0};
                    b_sh <= {b_sh[WIDTH-2:0], 1'b0};
                    cnt  <= cnt - CNT_W'(1);
                    if (last) begin
                        res_eq  <= e_nxt;
                        res_bgt <= g_nxt;
                        res_agt <= ~e_nxt & ~g_nxt;
                        state   <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy   = (state == S_SHIFT);
    assign done   = (state == S_DONE);
    assign a_eq_b = res_eq;
    assign b_gt_a = res_bgt;
    assign a_gt_b = res_agt;

endmodule

// File: tb/tb_bcs_serial_comparator.sv
// Directed bench: table of operand pairs on the full-width instance, plus hand-written
// sequences for ignored start, mid-shift reset and early exit.
module tb_bcs_serial_comparator;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start2;
    logic [7:0] a_in, b_in, a2, b2;
    logic       busy1, done1, eq1, bgt1, agt1;
    logic       busy2, done2, eq2, bgt2, agt2;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    bcs_serial_comparator #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .busy   (busy1),
        .done   (done1),
        .a_eq_b (eq1),
        .b_gt_a (bgt1),
        .a_gt_b (agt1)
    );

    bcs_serial_comparator #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut_ee (
        .clk    (clk),
        .rst    (rst),
        .start  (start2),
        .a_in   (a2),
        .b_in   (b2),
        .busy   (busy2),
        .done   (done2),
        .a_eq_b (eq2),
        .b_gt_a (bgt2),
        .a_gt_b (agt2)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] exp; // {a_eq_b, b_gt_a, a_gt_b}
        int         lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    // Start an operation; returns shift edges until done (-1 on timeout) and busy right after start.
    task automatic do_op(input bit sel, input logic [7:0] a, input logic [7:0] b,
                         input int glitch, output int lat, output logic fb);
        lat = -1;
        @(negedge clk);
        if (sel) begin start2 = 1'b1; a2 = a; b2 = b; end
        else begin start = 1'b1; a_in = a; b_in = b; end
        @(posedge clk);
        #1;
        start = 1'b0;
        start2 = 1'b0;
        @(negedge clk);
        fb = sel ? busy2 : busy1;
        for (int n = 1; n <= 40; n++) begin
            if (n == glitch) begin start = 1'b1; a_in = 8'hFF; b_in = 8'h00; end
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            if (sel ? done2 : done1) begin
                lat = n;
                break;
            end
        end
    endtask

    vec_t vecs[5];
    int   lat;
    logic fb;
    bit   saw_done;

    initial begin
        vecs[0] = '{a: 8'h5A, b: 8'h5A, exp: 3'b100, lat: 8};
        vecs[1] = '{a: 8'h3C, b: 8'h3D, exp: 3'b010, lat: 8};
        vecs[2] = '{a: 8'h80, b: 8'h7F, exp: 3'b001, lat: 8};
        vecs[3] = '{a: 8'h00, b: 8'hFF, exp: 3'b010, lat: 8};
        vecs[4] = '{a: 8'hFF, b: 8'hFE, exp: 3'b001, lat: 8};

        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        a_in = '0; b_in = '0; a2 = '0; b2 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {27'd0, busy1, done1, eq1, bgt1, agt1}, 32'd0);
        chk("reset_outputs_ee", {27'd0, busy2, done2, eq2, bgt2, agt2}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            do_op(1'b0, vecs[i].a, vecs[i].b, 0, lat, fb);
            chk($sformatf("busy_after_start[%0d]", i), {31'd0, fb}, 32'd1);
            chk($sformatf("latency[%0d]", i), lat, vecs[i].lat);
            chk($sformatf("result[%0d]", i), {29'd0, eq1, bgt1, agt1}, {29'd0, vecs[i].exp});
            for (int h = 0; h < 5; h++) begin
                @(negedge clk);
                chk($sformatf("hold[%0d.%0d]", i, h), {28'd0, done1, eq1, bgt1, agt1},
                    {28'd0, 1'b0, vecs[i].exp});
            end
        end

        // Start re-asserted with new operands during SHIFT must be ignored.
        do_op(1'b0, 8'h01, 8'h02, 2, lat, fb);
        chk("ignored_start_latency", lat, 8);
        chk("ignored_start_result", {29'd0, eq1, bgt1, agt1}, 32'b010);
        repeat (3) @(negedge clk);
        chk("ignored_start_no_restart", {30'd0, busy1, done1}, 32'd0);

        // Reset on the 4th shift edge discards the partial result.
        @(negedge clk);
        start = 1'b1; a_in = 8'h10; b_in = 8'h20;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midshift_reset", {27'd0, busy1, done1, eq1, bgt1, agt1}, 32'd0);
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done1 || busy1) saw_done = 1'b1;
        end
        chk("idle_after_reset", {31'd0, saw_done}, 32'd0);
        do_op(1'b0, 8'h10, 8'h10, 0, lat, fb);
        chk("post_reset_latency", lat, 8);
        chk("post_reset_result", {29'd0, eq1, bgt1, agt1}, 32'b100);

        // Early-exit instance.
        do_op(1'b1, 8'h80, 8'h00, 0, lat, fb);
        chk("ee_busy", {31'd0, fb}, 32'd1);
        chk("ee_msb_latency", lat, 1);
        chk("ee_msb_result", {29'd0, eq2, bgt2, agt2}, 32'b001);
        do_op(1'b1, 8'h10, 8'h00, 0, lat, fb);
        chk("ee_bit4_latency", lat, 4);
        chk("ee_bit4_result", {29'd0, eq2, bgt2, agt2}, 32'b001);
        do_op(1'b1, 8'h22, 8'h23, 0, lat, fb);
        chk("ee_lsb_latency", lat, 8);
        chk("ee_lsb_result", {29'd0, eq2, bgt2, agt2}, 32'b010);
        do_op(1'b1, 8'h22, 8'h22, 0, lat, fb);
        chk("ee_equal_latency", lat, 8);
        chk("ee_equal_result", {29'd0, eq2, bgt2, agt2}, 32'b100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
